size_conv_tx_pack: RTL and testbench

Parametrised successor to the 32-to-64 TX size converter. It packs a stream of 32-bit uDMA beats into RATIO×32-bit MRAM words, issuing one memory write per packed word with per-beat enables. Partial final words are handled explicitly. It also generates word, sector and chip erase sequences. It sits between the uDMA TX channel and the MRAM macro request/grant port.

---
 rtl/size_conv_pkg.sv | 25 ++
 rtl/size_conv_pack_buf.sv | 32 +++
 rtl/size_conv_tx_pack.sv | 131 +++++++++++++
 tb/tb_size_conv_tx_pack.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/size_conv_pkg.sv
// size_conv_pkg: command codes, FSM state encoding and parity helper shared by the TX size converter.
package size_conv_pkg;
    localparam logic [7:0] CMD_TX         = 8'h02;
    localparam logic [7:0] CMD_ERASE_CHIP = 8'h04;
    localparam logic [7:0] CMD_ERASE_SECT = 8'h08;
    localparam logic [7:0] CMD_ERASE_WORD = 8'h10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_WRITE = 3'd2;
    localparam logic [2:0] S_ERASE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = S_IDLE,
        FILL  = S_FILL,
        WRITE = S_WRITE,
        ERASE = S_ERASE,
        DONE  = S_DONE
    } state_e;

    function automatic logic even_par(input logic [7:0] b);
        return ^b;
    endfunction
endpackage

// File: rtl/size_conv_pack_buf.sv
// size_conv_pack_buf: RATIO-slot 32-bit packing buffer with per-slot enables.
module size_conv_pack_buf
    import size_conv_pkg::*;
#(
    parameter int RATIO = 2,
    parameter int IW    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  clr,
    input  logic [IW-1:0]         idx,
    input  logic [31:0]           din,
    output logic [32*RATIO-1:0]   data,
    output logic [RATIO-1:0]      be
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            be   <= '0;
        end else if (clr) begin
            data <= '0;
            be   <= '0;
        end else if (load) begin
            for (int k = 0; k < RATIO; k++)
                if (idx == IW'(k)) begin
                    data[32*k +: 32] <= din;
                    be[k]            <= 1'b1;
                end
        end
    end
endmodule

// File: rtl/size_conv_tx_pack.sv
// size_conv_tx_pack: packs 32-bit uDMA beats into RATIO*32-bit MRAM writes and sequences erases.
// Define SIZE_CONV_PARITY_EN to fill the pad field with per-byte even parity of the stored data.
module size_conv_tx_pack
    import size_conv_pkg::*;
#(
    parameter int RATIO      = 2,
    parameter int ADDR_W     = 16,
    parameter int TRANS_SIZE = 16,
    parameter int PAD_W      = 14,
    parameter int SECT_SHIFT = 8,
    parameter int ERS_W      = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_req_i,
    output logic                        cmd_gnt_o,
    input  logic [7:0]                  cmd_mode_i,
    input  logic [ADDR_W-1:0]           cmd_addr_i,
    input  logic [TRANS_SIZE-1:0]       cmd_size_i,
    input  logic [ERS_W-1:0]            cmd_ers_i,
    input  logic [31:0]                 tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic                        mem_req_o,
    input  logic                        mem_gnt_i,
    output logic [ADDR_W-1:0]           mem_addr_o,
    output logic [32*RATIO+PAD_W-1:0]   mem_wdata_o,
    output logic [RATIO-1:0]            mem_be_o,
    output logic                        mem_eot_o,
    output logic                        busy_o,
    output logic                        tx_done_o,
    output logic                        erase_done_o,
    output logic                        err_o
);
    localparam int DW = 32 * RATIO;
    localparam int IW = RATIO > 1 ? $clog2(RATIO) : 1;
    localparam int RW = TRANS_SIZE + 1;

    state_e            state;
    logic              is_tx, is_chip, is_sect;
    logic [ADDR_W-1:0] addr;
    logic [RW-1:0]     rem;
    logic [IW-1:0]     idx;
    logic [ERS_W-1:0]  cnt;
    logic [DW-1:0]     buf_data, data_out;
    logic [RATIO-1:0]  buf_be;
    logic [PAD_W-1:0]  pad;
    logic              legal, accept, fill_last;

    assign legal     = cmd_mode_i inside {CMD_TX, CMD_ERASE_CHIP, CMD_ERASE_SECT, CMD_ERASE_WORD};
    assign accept    = state == FILL && tx_valid_i;
    assign fill_last = idx == IW'(RATIO - 1) || rem <= RW'(4);

    assign cmd_gnt_o    = state == IDLE && cmd_req_i;
    assign err_o        = cmd_gnt_o && !legal;
    assign busy_o       = cmd_req_i || state != IDLE;
    assign tx_ready_o   = state == FILL;
    assign mem_req_o    = state == WRITE || state == ERASE;
    assign mem_addr_o   = addr;
    assign data_out     = state == ERASE ? '0 : ~buf_data;
    assign mem_wdata_o  = {pad, data_out};
    assign mem_be_o     = state == ERASE ? '1 : state == WRITE ? buf_be : '0;
    assign mem_eot_o    = state == WRITE ? rem == '0 : state == ERASE && (is_chip || cnt == '0);
    assign tx_done_o    = state == DONE && is_tx;
    assign erase_done_o = state == DONE && !is_tx;

`ifdef SIZE_CONV_PARITY_EN
    localparam int NPAR = PAD_W < DW / 8 ? PAD_W : DW / 8;
    always_comb begin
        pad = '0;
        for (int i = 0; i < NPAR; i++) pad[i] = even_par(data_out[8*i +: 8]);
    end
`else
    assign pad = '0;
`endif

    size_conv_pack_buf #(.RATIO(RATIO), .IW(IW)) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .clr   (state == WRITE && mem_gnt_i),
        .idx   (idx),
        .din   (tx_data_i),
        .data  (buf_data),
        .be    (buf_be)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            is_tx   <= 1'b0;
            is_chip <= 1'b0;
            is_sect <= 1'b0;
            addr    <= '0;
            rem     <= '0;
            idx     <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_req_i && legal) begin
                    addr    <= cmd_addr_i;
                    rem     <= (RW'(cmd_size_i) + RW'(3)) & ~RW'(3);
                    idx     <= '0;
                    cnt     <= cmd_ers_i;
                    is_tx   <= cmd_mode_i == CMD_TX;
                    is_chip <= cmd_mode_i == CMD_ERASE_CHIP;
                    is_sect <= cmd_mode_i == CMD_ERASE_SECT;
                    state   <= cmd_mode_i != CMD_TX ? ERASE : cmd_size_i == '0 ? DONE : FILL;
                end
                FILL: if (tx_valid_i) begin
                    rem <= rem - RW'(4);
                    if (fill_last) state <= WRITE;
                    else idx <= idx + IW'(1);
                end
                WRITE: if (mem_gnt_i) begin
                    addr  <= addr + ADDR_W'(1);
                    idx   <= '0;
                    state <= rem == '0 ? DONE : FILL;
                end
                ERASE: if (mem_gnt_i) begin
                    cnt  <= cnt - ERS_W'(1);
                    // sector stride: bump the sector field and zero the in-sector offset
                    addr <= is_sect ? ((addr >> SECT_SHIFT) + ADDR_W'(1)) << SECT_SHIFT : addr + ADDR_W'(1);
                    if (is_chip || cnt == '0) state <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_size_conv_tx_pack.sv
// tb_size_conv_tx_pack: directed scoreboard bench for RATIO=2 and RATIO=4 instances.
module tb_size_conv_tx_pack;
    typedef struct {
        logic [15:0]  addr;
        logic [141:0] wdata;
        logic [3:0]   be;
        logic         eot;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic cmd_req [2], cmd_gnt [2], tx_valid [2], tx_ready [2], mem_req [2], mem_gnt [2];
    logic mem_eot [2], busy [2], tx_done [2], erase_done [2], err [2];
    logic [7:0]  cmd_mode [2];
    logic [15:0] cmd_addr [2], cmd_size [2], mem_addr [2];
    logic [9:0]  cmd_ers [2];
    logic [31:0] tx_data [2];
    logic [77:0]  wd2;
    logic [141:0] wd4;
    logic [1:0]   be2;
    logic [3:0]   be4;

    int total = 0;
    int bad = 0;
    exp_t q0 [$];
    exp_t q1 [$];
    exp_t e0, e1, ex;

    size_conv_tx_pack u2 (
        .clk(clk), .rst_n(rst_n), .cmd_req_i(cmd_req[0]), .cmd_gnt_o(cmd_gnt[0]),
        .cmd_mode_i(cmd_mode[0]), .cmd_addr_i(cmd_addr[0]), .cmd_size_i(cmd_size[0]),
        .cmd_ers_i(cmd_ers[0]), .tx_data_i(tx_data[0]), .tx_valid_i(tx_valid[0]),
        .tx_ready_o(tx_ready[0]), .mem_req_o(mem_req[0]), .mem_gnt_i(mem_gnt[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(wd2), .mem_be_o(be2), .mem_eot_o(mem_eot[0]),
        .busy_o(busy[0]), .tx_done_o(tx_done[0]), .erase_done_o(erase_done[0]), .err_o(err[0])
    );

    size_conv_tx_pack #(.RATIO(4)) u4 (
        .clk(clk), .rst_n(rst_n), .cmd_req_i(cmd_req[1]), .cmd_gnt_o(cmd_gnt[1]),
        .cmd_mode_i(cmd_mode[1]), .cmd_addr_i(cmd_addr[1]), .cmd_size_i(cmd_size[1]),
        .cmd_ers_i(cmd_ers[1]), .tx_data_i(tx_data[1]), .tx_valid_i(tx_valid[1]),
        .tx_ready_o(tx_ready[1]), .mem_req_o(mem_req[1]), .mem_gnt_i(mem_gnt[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(wd4), .mem_be_o(be4), .mem_eot_o(mem_eot[1]),
        .busy_o(busy[1]), .tx_done_o(tx_done[1]), .erase_done_o(erase_done[1]), .err_o(err[1])
    );

    task automatic chk(input logic [255:0] obs, input logic [255:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // raw is the packed buffer content; the memory sees it inverted, with parity over stored bytes
    function automatic exp_t mk(input logic [15:0] a, input logic [127:0] raw, input int nb,
                                input logic [3:0] be, input logic eot);
        exp_t e;
        e.addr = a;
        e.be = be;
        e.eot = eot;
        e.wdata = '0;
        for (int i = 0; i < nb * 8; i++) e.wdata[i] = ~raw[i];
`ifdef SIZE_CONV_PARITY_EN
        for (int i = 0; i < 14 && i < nb; i++) e.wdata[nb*8+i] = ^e.wdata[i*8 +: 8];
`endif
        return e;
    endfunction

    task automatic push(input int j, input exp_t e);
        if (j == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    always @(negedge clk) if (rst_n && mem_req[0] && mem_gnt[0]) begin
        chk(q0.size() > 0, 1'b1, "r2_write_expected");
        if (q0.size() > 0) begin
            e0 = q0.pop_front();
            chk(mem_addr[0], e0.addr, "r2_addr");
            chk(wd2, e0.wdata, "r2_wdata");
            chk(be2, e0.be, "r2_be");
            chk(mem_eot[0], e0.eot, "r2_eot");
        end
    end

    always @(negedge clk) if (rst_n && mem_req[1] && mem_gnt[1]) begin
        chk(q1.size() > 0, 1'b1, "r4_write_expected");
        if (q1.size() > 0) begin
            e1 = q1.pop_front();
            chk(mem_addr[1], e1.addr, "r4_addr");
            chk(wd4, e1.wdata, "r4_wdata");
            chk(be4, e1.be, "r4_be");
            chk(mem_eot[1], e1.eot, "r4_eot");
        end
    end

    task automatic cmd(input int j, input logic [7:0] mode, input logic [15:0] a,
                       input logic [15:0] sz, input logic [9:0] ers, input logic err_exp);
        @(posedge clk); #1;
        cmd_req[j] = 1'b1;
        cmd_mode[j] = mode;
        cmd_addr[j] = a;
        cmd_size[j] = sz;
        cmd_ers[j] = ers;
        @(negedge clk);
        chk(cmd_gnt[j], 1'b1, "cmd_gnt");
        chk(err[j], err_exp, "cmd_err");
        chk(busy[j], 1'b1, "cmd_busy");
        @(posedge clk); #1;
        cmd_req[j] = 1'b0;
    endtask

    task automatic beat(input int j, input logic [31:0] d);
        int n = 0;
        tx_valid[j] = 1'b1;
        tx_data[j] = d;
        @(negedge clk);
        while (!tx_ready[j] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(tx_ready[j], 1'b1, "beat_ready");
        @(posedge clk); #1;
        tx_valid[j] = 1'b0;
    endtask

    task automatic wait_done(input int j, input logic tx);
        int n = 0;
        @(negedge clk);
        while (!(tx_done[j] || erase_done[j]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(tx_done[j], tx, "tx_done");
        chk(erase_done[j], !tx, "erase_done");
        chk(j == 0 ? q0.size() : q1.size(), 0, "queue_drained");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        for (int j = 0; j < 2; j++) begin
            cmd_req[j] = 1'b0;
            cmd_mode[j] = '0;
            cmd_addr[j] = '0;
            cmd_size[j] = '0;
            cmd_ers[j] = '0;
            tx_valid[j] = 1'b0;
            tx_data[j] = '0;
            mem_gnt[j] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int j = 0; j < 2; j++)
            chk({mem_req[j], tx_ready[j], mem_eot[j], busy[j], tx_done[j], erase_done[j], err[j], cmd_gnt[j]},
                8'h00, "reset_outputs");
        chk({be4, be2}, 6'b0, "reset_be");
        @(posedge clk); #1;
        rst_n = 1'b1;

        push(0, mk(16'h0010, {64'h0, 32'hB0B1B2B3, 32'hA0A1A2A3}, 8, 4'b0011, 1'b0));
        push(0, mk(16'h0011, {64'h0, 32'hD0D1D2D3, 32'hC0C1C2C3}, 8, 4'b0011, 1'b1));
        cmd(0, 8'h02, 16'h0010, 16'd16, 10'd0, 1'b0);
        beat(0, 32'hA0A1A2A3);
        beat(0, 32'hB0B1B2B3);
        beat(0, 32'hC0C1C2C3);
        beat(0, 32'hD0D1D2D3);
        wait_done(0, 1'b1);

        mem_gnt[0] = 1'b0;
        ex = mk(16'h0020, {64'h0, 32'h0F0F1234, 32'hE1E2E3E4}, 8, 4'b0011, 1'b1);
        push(0, ex);
        cmd(0, 8'h02, 16'h0020, 16'd8, 10'd0, 1'b0);
        beat(0, 32'hE1E2E3E4);
        beat(0, 32'h0F0F1234);
        tx_valid[0] = 1'b1;
        tx_data[0] = 32'h66666666;
        repeat (5) begin
            @(negedge clk);
            chk(mem_req[0], 1'b1, "stall_req");
            chk(mem_addr[0], ex.addr, "stall_addr");
            chk(wd2, ex.wdata, "stall_wdata");
            chk(be2, ex.be, "stall_be");
            chk(tx_ready[0], 1'b0, "stall_ready");
        end
        @(posedge clk); #1;
        mem_gnt[0] = 1'b1;
        wait_done(0, 1'b1);
        tx_valid[0] = 1'b0;

        push(0, mk(16'h0123, '1, 8, 4'b0011, 1'b0));
        push(0, mk(16'h0200, '1, 8, 4'b0011, 1'b0));
        push(0, mk(16'h0300, '1, 8, 4'b0011, 1'b1));
        cmd(0, 8'h08, 16'h0123, 16'd0, 10'd2, 1'b0);
        wait_done(0, 1'b0);

        push(0, mk(16'h0005, '1, 8, 4'b0011, 1'b0));
        push(0, mk(16'h0006, '1, 8, 4'b0011, 1'b1));
        cmd(0, 8'h10, 16'h0005, 16'd0, 10'd1, 1'b0);
        wait_done(0, 1'b0);

        push(0, mk(16'h0777, '1, 8, 4'b0011, 1'b1));
        cmd(0, 8'h04, 16'h0777, 16'd0, 10'd5, 1'b0);
        wait_done(0, 1'b0);

        cmd(0, 8'h02, 16'h0030, 16'd0, 10'd0, 1'b0);
        chk(mem_req[0], 1'b0, "size0_no_req");
        wait_done(0, 1'b1);

        cmd(0, 8'h55, 16'h0040, 16'd4, 10'd0, 1'b1);
        @(negedge clk);
        chk(busy[0], 1'b0, "illegal_busy_drop");
        chk(mem_req[0], 1'b0, "illegal_no_req");

        push(0, mk(16'hFFFF, {64'h0, 32'h13579BDF, 32'h02468ACE}, 8, 4'b0011, 1'b0));
        push(0, mk(16'h0000, {64'h0, 32'hFFFF0000, 32'h0000FFFF}, 8, 4'b0011, 1'b1));
        cmd(0, 8'h02, 16'hFFFF, 16'd16, 10'd0, 1'b0);
        beat(0, 32'h02468ACE);
        beat(0, 32'h13579BDF);
        beat(0, 32'h0000FFFF);
        beat(0, 32'hFFFF0000);
        wait_done(0, 1'b1);

        push(1, mk(16'h0040, {64'h0, 32'h22223333, 32'h44445555}, 16, 4'b0011, 1'b1));
        cmd(1, 8'h02, 16'h0040, 16'd6, 10'd0, 1'b0);
        beat(1, 32'h44445555);
        beat(1, 32'h22223333);
        wait_done(1, 1'b1);

        push(1, mk(16'h0100, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 16, 4'b1111, 1'b1));
        cmd(1, 8'h02, 16'h0100, 16'd13, 10'd0, 1'b0);
        beat(1, 32'h11111111);
        beat(1, 32'h22222222);
        beat(1, 32'h33333333);
        beat(1, 32'h44444444);
        wait_done(1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
